rob_cmpl_tracker: RTL and testbench
===================================

# rob_cmpl_tracker

Parametrised completion-status tracker for the reorder buffer. It holds one done/call/ret/exception record per ROB slot. The record is set by any of `WB_PORTS` writeback ports, cleared on dispatch allocation, commit and flush, and read by `COMMIT_W` banked commit lanes. It sits between the execution-unit writeback buses and the commit stage, and generalises the fixed 32-entry, 4-writer, 2-lane status file. It adds the following:
- depth, port and lane parameters;
- an allocation clear;
- exception cause capture;
- an optional same-cycle bypass.

## Interface
Parameters:
- `ROB_DEPTH`, default 32: number of slots; must be a power of two and at least `COMMIT_W`.
- `WB_PORTS`, default 4: number of writeback ports. Port 0 is the branch ALU and is the only port whose call/ret flags are honoured.
- `COMMIT_W`, default 2: number of commit and allocation lanes. Slot s belongs to bank s % `COMMIT_W`.
- `CAUSE_W`, default 5: width of the exception cause.
- `BYPASS`, default 0: 1 = lane outputs see same-cycle writebacks.
- `IDX_W`: local parameter, `$clog2(ROB_DEPTH)`.

Ports:
- `cpu_clk_i`  in  1  clock
- `cpu_rst_i`  in  1  reset; asynchronous assert, active-high; clears all state
- `flush_i`  in  1  synchronous full pipeline flush
- `alloc_valid_i`  in  `COMMIT_W`  dispatch allocating a slot on lane l
- `alloc_slot_i`  in  `COMMIT_W*IDX_W`  allocated slot per lane
- `wb_valid_i`  in  `WB_PORTS`  writeback completion strobe
- `wb_slot_i`  in  `WB_PORTS*IDX_W`  completing slot
- `wb_call_i`, `wb_ret_i`  in  `WB_PORTS` each  call/ret flags; bits 1..`WB_PORTS`-1 ignored
- `wb_exc_i`  in  `WB_PORTS`  completion raised an exception
- `wb_cause_i`  in  `WB_PORTS*CAUSE_W`  exception cause
- `cm_slot_i`  in  `COMMIT_W*IDX_W`  slot examined by commit lane l
- `cm_commit_i`  in  `COMMIT_W`  lane l retires its slot this cycle
- `cm_done_o`, `cm_call_o`, `cm_ret_o`, `cm_exc_o`  out  `COMMIT_W` each  record of `cm_slot_i[l]`
- `cm_cause_o`  out  `COMMIT_W*CAUSE_W`  stored cause
- `done_cnt_o`  out  `IDX_W+1`  number of slots with done set

## Operation
- Per-slot state: done, call, ret, exc, cause[`CAUSE_W`]. All zero at reset.
- Per-slot update priority, highest first:
  1. reset;
  2. flush (all fields to 0);
  3. commit clear: lane l = slot % `COMMIT_W`, with `cm_commit_i[l]` and `cm_slot_i[l]`==slot;
  4. allocation clear: any lane with a valid allocation of this slot;
  5. writeback set: done=1.
- On writeback set:
  - call |= port-0 call; ret |= port-0 ret.
  - exc |= any exc among the matching ports.
  - cause is taken from the lowest-index matching port with exc=1, and is written only when exc was previously 0.
- Several ports hitting the same slot in one cycle are legal. Their flags are ORed.
- A commit on lane l for a slot outside bank l has no effect; the bench flags it as an error.
- Lane outputs are a combinational read of `cm_slot_i[l]`.
  - With `BYPASS`=1, same-cycle writebacks to that slot are additionally ORed into done/call/ret/exc.
  - With `BYPASS`=1, cause comes from the writeback if stored exc=0.
  - Bypass is suppressed during `flush_i`.
- `done_cnt_o` is a registered population count of the done bits. It is 0 after reset and flush.

## Timing
- Writeback in cycle N is visible on the lane outputs:
  - in cycle N+1 when `BYPASS`=0;
  - in cycle N when `BYPASS`=1.
- Commit or allocation clear in cycle N: the slot reads 0 from N+1.
- Commit and writeback to the same slot in the same cycle: the commit wins and the slot ends at 0.
- Allocation and writeback to the same slot in the same cycle: the allocation wins.
- `done_cnt_o` reflects the state after edge N at N+1. It never exceeds `ROB_DEPTH`.
- Reset asserted mid-operation clears everything immediately. All outputs are 0 while reset is held, bypass included.

## Structure
- Shared package `rob_pkg`: the `rob_rec_t` struct (done, call, ret, exc, cause), the `CAUSE_W` default, and the `IDX_W` helper function.
- One sub-module, `rob_slot_rec`: a single slot's priority update logic. It is instantiated `ROB_DEPTH` times under generate, with its bank index as a parameter.
- The top level holds the port-match decode, the lane read muxes, the bypass and the popcount.

## Test plan
- Writeback on port 2 to slot 5 (`BYPASS`=0) -> `cm_done_o[1]`=0 in the same cycle and 1 the next cycle, with `cm_slot_i[1]`=5.
- Port 0 writes slot 4 with call=1, and port 1 writes slot 4 with exc=1, cause=7, in the same cycle -> slot 4 reads done=1, call=1, exc=1, cause=7.
- Slot 6: commit on lane 0 and a port-3 writeback in the same cycle -> next cycle slot 6 reads all 0 and `done_cnt_o` drops by 1.
- Write 32 different slots, then assert `flush_i` -> `done_cnt_o` goes 32 then 0, and every lane reads 0.
- `BYPASS`=1 with a writeback to slot 9 while lane 1 reads slot 9 -> `cm_done_o[1]`=1 in the same cycle. Repeat with `flush_i` high -> 0.
- Assert `cpu_rst_i` asynchronously mid-cycle after filling slots -> all outputs 0 before the next edge, and `done_cnt_o`=0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder-buffer completion tracker.
package rob_pkg;

    localparam int CAUSE_W = 5;

    typedef struct packed {
        logic               done;
        logic               call;
        logic               ret;
        logic               exc;
        logic [CAUSE_W-1:0] cause;
    } rob_rec_t;

    // Index width for a slot array; a single-slot array still needs one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rob_slot_rec.sv
// One ROB slot's completion record with its clear/set priority chain.
module rob_slot_rec #(
    parameter int IDX_W    = 5,
    parameter int CAUSE_W  = 5,
    parameter int COMMIT_W = 2,
    parameter int SLOT     = 0,
    parameter int BANK     = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [COMMIT_W-1:0]       cm_commit_i,
    input  logic [COMMIT_W*IDX_W-1:0] cm_slot_i,
    input  logic                      alloc_clr_i,
    input  logic                      wb_set_i,
    input  logic                      wb_call_i,
    input  logic                      wb_ret_i,
    input  logic                      wb_exc_i,
    input  logic [CAUSE_W-1:0]        wb_cause_i,
    output logic                      done_o,
    output logic                      call_o,
    output logic                      ret_o,
    output logic                      exc_o,
    output logic [CAUSE_W-1:0]        cause_o,
    output logic                      done_d_o
);

    logic               done_q, call_q, ret_q, exc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic               done_d, call_d, ret_d, exc_d;
    logic [CAUSE_W-1:0] cause_d;
    logic               commit_clr;

    // Only the lane owning this slot's bank may retire it.
    always_comb begin
        commit_clr = 1'b0;
        for (int l = 0; l < COMMIT_W; l++) begin
            if (l == BANK && cm_commit_i[l] &&
                cm_slot_i[l*IDX_W +: IDX_W] == IDX_W'(SLOT)) begin
                commit_clr = 1'b1;
            end
        end
    end

    always_comb begin
        done_d  = done_q;
        call_d  = call_q;
        ret_d   = ret_q;
        exc_d   = exc_q;
        cause_d = cause_q;
        if (flush_i || commit_clr || alloc_clr_i) begin
            done_d  = 1'b0;
            call_d  = 1'b0;
            ret_d   = 1'b0;
            exc_d   = 1'b0;
            cause_d = '0;
        end else if (wb_set_i) begin
            done_d = 1'b1;
            call_d = call_q | wb_call_i;
            ret_d  = ret_q | wb_ret_i;
            exc_d  = exc_q | wb_exc_i;
            // The first exception recorded for a slot keeps its cause.
            if (!exc_q && wb_exc_i) begin
                cause_d = wb_cause_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q  <= 1'b0;
            call_q  <= 1'b0;
            ret_q   <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= '0;
        end else begin
            done_q  <= done_d;
            call_q  <= call_d;
            ret_q   <= ret_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
        end
    end

    assign done_o   = done_q;
    assign call_o   = call_q;
    assign ret_o    = ret_q;
    assign exc_o    = exc_q;
    assign cause_o  = cause_q;
    assign done_d_o = done_d;

endmodule

// File: rtl/rob_cmpl_tracker.sv
// Per-slot completion status for the ROB: writeback set, alloc/commit/flush
// clear, banked commit-lane reads with optional same-cycle bypass.
module rob_cmpl_tracker
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH = 32,
    parameter int WB_PORTS  = 4,
    parameter int COMMIT_W  = 2,
    parameter int CAUSE_W   = rob_pkg::CAUSE_W,
    parameter int BYPASS    = 0,
    localparam int IDX_W    = idx_w(ROB_DEPTH)
) (
    input  logic                         cpu_clk_i,
    input  logic                         cpu_rst_i,
    input  logic                         flush_i,
    input  logic [COMMIT_W-1:0]          alloc_valid_i,
    input  logic [COMMIT_W*IDX_W-1:0]    alloc_slot_i,
    input  logic [WB_PORTS-1:0]          wb_valid_i,
    input  logic [WB_PORTS*IDX_W-1:0]    wb_slot_i,
    input  logic [WB_PORTS-1:0]          wb_call_i,
    input  logic [WB_PORTS-1:0]          wb_ret_i,
    input  logic [WB_PORTS-1:0]          wb_exc_i,
    input  logic [WB_PORTS*CAUSE_W-1:0]  wb_cause_i,
    input  logic [COMMIT_W*IDX_W-1:0]    cm_slot_i,
    input  logic [COMMIT_W-1:0]          cm_commit_i,
    output logic [COMMIT_W-1:0]          cm_done_o,
    output logic [COMMIT_W-1:0]          cm_call_o,
    output logic [COMMIT_W-1:0]          cm_ret_o,
    output logic [COMMIT_W-1:0]          cm_exc_o,
    output logic [COMMIT_W*CAUSE_W-1:0]  cm_cause_o,
    output logic [IDX_W:0]               done_cnt_o
);

    logic [ROB_DEPTH-1:0] done_q, call_q, ret_q, exc_q, done_d;
    logic [CAUSE_W-1:0]   cause_q [ROB_DEPTH];
    logic [IDX_W:0]       done_cnt_q, done_cnt_d;
    logic                 unused_flags;

    // Call/ret are meaningful on the branch port only.
    assign unused_flags = ^{wb_call_i, wb_ret_i};

    for (genvar s = 0; s < ROB_DEPTH; s++) begin : g_slot
        logic               set, call, ret, exc, alloc_clr, found;
        logic [CAUSE_W-1:0] cause;

        always_comb begin
            set       = 1'b0;
            exc       = 1'b0;
            found     = 1'b0;
            cause     = '0;
            alloc_clr = 1'b0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid_i[p] && wb_slot_i[p*IDX_W +: IDX_W] == IDX_W'(s)) begin
                    set = 1'b1;
                    exc = exc | wb_exc_i[p];
                    if (wb_exc_i[p] && !found) begin
                        found = 1'b1;
                        cause = wb_cause_i[p*CAUSE_W +: CAUSE_W];
                    end
                end
            end
            call = wb_valid_i[0] && wb_call_i[0] && wb_slot_i[IDX_W-1:0] == IDX_W'(s);
            ret  = wb_valid_i[0] && wb_ret_i[0]  && wb_slot_i[IDX_W-1:0] == IDX_W'(s);
            for (int l = 0; l < COMMIT_W; l++) begin
                if (alloc_valid_i[l] && alloc_slot_i[l*IDX_W +: IDX_W] == IDX_W'(s)) begin
                    alloc_clr = 1'b1;
                end
            end
        end

        rob_slot_rec #(
            .IDX_W    (IDX_W),
            .CAUSE_W  (CAUSE_W),
            .COMMIT_W (COMMIT_W),
            .SLOT     (s),
            .BANK     (s % COMMIT_W)
        ) u_rec (
            .clk_i       (cpu_clk_i),
            .rst_i       (cpu_rst_i),
            .flush_i     (flush_i),
            .cm_commit_i (cm_commit_i),
            .cm_slot_i   (cm_slot_i),
            .alloc_clr_i (alloc_clr),
            .wb_set_i    (set),
            .wb_call_i   (call),
            .wb_ret_i    (ret),
            .wb_exc_i    (exc),
            .wb_cause_i  (cause),
            .done_o      (done_q[s]),
            .call_o      (call_q[s]),
            .ret_o       (ret_q[s]),
            .exc_o       (exc_q[s]),
            .cause_o     (cause_q[s]),
            .done_d_o    (done_d[s])
        );
    end

    // Lane reads; bypass merges writebacks landing on the examined slot now.
    always_comb begin
        logic [IDX_W-1:0]   sel;
        logic               byp_en, b_done, b_call, b_ret, b_exc;
        logic [CAUSE_W-1:0] b_cause;
        cm_done_o  = '0;
        cm_call_o  = '0;
        cm_ret_o   = '0;
        cm_exc_o   = '0;
        cm_cause_o = '0;
        byp_en     = (BYPASS != 0) && !flush_i && !cpu_rst_i;
        for (int l = 0; l < COMMIT_W; l++) begin
            sel     = cm_slot_i[l*IDX_W +: IDX_W];
            b_done  = 1'b0;
            b_call  = 1'b0;
            b_ret   = 1'b0;
            b_exc   = 1'b0;
            b_cause = '0;
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
                if (byp_en && wb_valid_i[p] && wb_slot_i[p*IDX_W +: IDX_W] == sel) begin
                    b_done = 1'b1;
                    if (wb_exc_i[p]) begin
                        b_exc   = 1'b1;
                        b_cause = wb_cause_i[p*CAUSE_W +: CAUSE_W];
                    end
                    if (p == 0) begin
                        b_call = wb_call_i[0];
                        b_ret  = wb_ret_i[0];
                    end
                end
            end
            cm_done_o[l] = done_q[sel] | b_done;
            cm_call_o[l] = call_q[sel] | b_call;
            cm_ret_o[l]  = ret_q[sel]  | b_ret;
            cm_exc_o[l]  = exc_q[sel]  | b_exc;
            cm_cause_o[l*CAUSE_W +: CAUSE_W] = (exc_q[sel] || !b_exc) ? cause_q[sel] : b_cause;
        end
    end

    // Count from next-state so the total moves on the same edge as the bits.
    always_comb begin
        done_cnt_d = '0;
        for (int s = 0; s < ROB_DEPTH; s++) begin
            done_cnt_d = done_cnt_d + (IDX_W+1)'(done_d[s]);
        end
    end

    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            done_cnt_q <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done_cnt_o = done_cnt_q;

endmodule

// File: tb/tb_rob_cmpl_tracker.sv
// Directed bench for rob_cmpl_tracker: one instance without and one with bypass.
module tb_rob_cmpl_tracker;
    import rob_pkg::*;

    localparam int IW = 5;
    localparam int CW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  alloc_valid;
    logic [9:0]  alloc_slot;
    logic [3:0]  wb_valid, wb_call, wb_ret, wb_exc;
    logic [19:0] wb_slot, wb_cause;
    logic [9:0]  cm_slot;
    logic [1:0]  cm_commit;
    logic [1:0]  o0_done, o0_call, o0_ret, o0_exc, o1_done, o1_call, o1_ret, o1_exc;
    logic [9:0]  o0_cause, o1_cause;
    logic [5:0]  cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rob_cmpl_tracker #(.BYPASS(0)) dut0 (
        .cpu_clk_i(clk), .cpu_rst_i(rst), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_slot_i(alloc_slot),
        .wb_valid_i(wb_valid), .wb_slot_i(wb_slot), .wb_call_i(wb_call),
        .wb_ret_i(wb_ret), .wb_exc_i(wb_exc), .wb_cause_i(wb_cause),
        .cm_slot_i(cm_slot), .cm_commit_i(cm_commit),
        .cm_done_o(o0_done), .cm_call_o(o0_call), .cm_ret_o(o0_ret),
        .cm_exc_o(o0_exc), .cm_cause_o(o0_cause), .done_cnt_o(cnt0)
    );

    rob_cmpl_tracker #(.BYPASS(1)) dut1 (
        .cpu_clk_i(clk), .cpu_rst_i(rst), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_slot_i(alloc_slot),
        .wb_valid_i(wb_valid), .wb_slot_i(wb_slot), .wb_call_i(wb_call),
        .wb_ret_i(wb_ret), .wb_exc_i(wb_exc), .wb_cause_i(wb_cause),
        .cm_slot_i(cm_slot), .cm_commit_i(cm_commit),
        .cm_done_o(o1_done), .cm_call_o(o1_call), .cm_ret_o(o1_ret),
        .cm_exc_o(o1_exc), .cm_cause_o(o1_cause), .done_cnt_o(cnt1)
    );

    function automatic rob_rec_t rd(input int d, input int l);
        rob_rec_t r;
        if (d == 0) r = '{o0_done[l], o0_call[l], o0_ret[l], o0_exc[l], o0_cause[l*CW +: CW]};
        else        r = '{o1_done[l], o1_call[l], o1_ret[l], o1_exc[l], o1_cause[l*CW +: CW]};
        return r;
    endfunction

    function automatic rob_rec_t mk(input bit d, input bit c, input bit r, input bit e, input int cause);
        rob_rec_t x;
        x = '{d, c, r, e, CW'(cause)};
        return x;
    endfunction

    task automatic idle();
        flush = 0; alloc_valid = '0; alloc_slot = '0;
        wb_valid = '0; wb_slot = '0; wb_call = '0; wb_ret = '0; wb_exc = '0; wb_cause = '0;
        cm_slot = '0; cm_commit = '0;
    endtask

    task automatic set_wb(input int p, input int slot, input bit c, input bit r, input bit e, input int cause);
        wb_valid[p] = 1'b1;
        wb_slot[p*IW +: IW] = IW'(slot);
        wb_call[p] = c;
        wb_ret[p] = r;
        wb_exc[p] = e;
        wb_cause[p*CW +: CW] = CW'(cause);
    endtask

    task automatic test_reset();
        @(negedge clk); idle(); set_wb(0, 0, 1, 0, 0, 0); cm_slot[IW-1:0] = '0; #1;
        checks++; if (cnt0 !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt0); end
        checks++; if (rd(0, 0) !== mk(0, 0, 0, 0, 0)) begin errors++; $display("FAIL reset_rec: got %h want 0", rd(0, 0)); end
        checks++; if (rd(1, 0) !== mk(0, 0, 0, 0, 0)) begin errors++; $display("FAIL reset_bypass: got %h want 0", rd(1, 0)); end
        @(negedge clk); rst = 0; idle();
    endtask

    task automatic test_wb_latency();
        @(negedge clk); idle(); set_wb(2, 5, 0, 0, 0, 0); cm_slot[IW +: IW] = 5; #1;
        checks++; if (o0_done[1] !== 1'b0) begin errors++; $display("FAIL wb_same_cycle: got %b want 0", o0_done[1]); end
        checks++; if (o1_done[1] !== 1'b1) begin errors++; $display("FAIL wb_bypass_same_cycle: got %b want 1", o1_done[1]); end
        @(negedge clk); idle(); cm_slot[IW +: IW] = 5; #1;
        checks++; if (o0_done[1] !== 1'b1) begin errors++; $display("FAIL wb_next_cycle: got %b want 1", o0_done[1]); end
        checks++; if (cnt0 !== 6'd1) begin errors++; $display("FAIL wb_cnt: got %0d want 1", cnt0); end
    endtask

    task automatic test_merge();
        @(negedge clk); idle();
        set_wb(0, 4, 1, 0, 0, 0); set_wb(1, 4, 0, 1, 1, 7); set_wb(3, 4, 0, 0, 1, 12);
        @(negedge clk); idle(); cm_slot[IW-1:0] = 4; #1;
        checks++; if (rd(0, 0) !== mk(1, 1, 0, 1, 7)) begin errors++; $display("FAIL merge_rec: got %h want %h", rd(0, 0), mk(1, 1, 0, 1, 7)); end
        checks++; if (cnt0 !== 6'd2) begin errors++; $display("FAIL merge_cnt: got %0d want 2", cnt0); end
        @(negedge clk); idle(); set_wb(2, 4, 0, 0, 1, 9);
        @(negedge clk); idle(); cm_slot[IW-1:0] = 4; #1;
        checks++; if (rd(0, 0) !== mk(1, 1, 0, 1, 7)) begin errors++; $display("FAIL cause_sticky: got %h want %h", rd(0, 0), mk(1, 1, 0, 1, 7)); end
    endtask

    task automatic test_clear_priority();
        @(negedge clk); idle(); set_wb(3, 6, 0, 0, 1, 3);
        @(negedge clk); idle(); #1;
        checks++; if (cnt0 !== 6'd3) begin errors++; $display("FAIL pre_commit_cnt: got %0d want 3", cnt0); end
        cm_commit[0] = 1'b1; cm_slot[IW-1:0] = 6; set_wb(3, 6, 0, 0, 0, 0);
        @(negedge clk); idle(); cm_slot[IW-1:0] = 6; #1;
        checks++; if (rd(0, 0) !== mk(0, 0, 0, 0, 0)) begin errors++; $display("FAIL commit_wins: got %h want 0", rd(0, 0)); end
        checks++; if (cnt0 !== 6'd2) begin errors++; $display("FAIL commit_cnt: got %0d want 2", cnt0); end
        cm_commit[1] = 1'b1; cm_slot[IW +: IW] = 4;
        @(negedge clk); idle(); cm_slot[IW +: IW] = 4; #1;
        checks++; if (o0_done[1] !== 1'b1) begin errors++; $display("FAIL wrong_bank_commit: got %b want 1", o0_done[1]); end
        alloc_valid[0] = 1'b1; alloc_slot[IW-1:0] = 5; set_wb(1, 5, 0, 0, 0, 0);
        @(negedge clk); idle(); cm_slot[IW-1:0] = 5; #1;
        checks++; if (rd(0, 0) !== mk(0, 0, 0, 0, 0)) begin errors++; $display("FAIL alloc_wins: got %h want 0", rd(0, 0)); end
        checks++; if (cnt0 !== 6'd1) begin errors++; $display("FAIL alloc_cnt: got %0d want 1", cnt0); end
    endtask

    task automatic test_fill_flush();
        @(negedge clk); idle(); flush = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); idle();
            for (int p = 0; p < 4; p++) set_wb(p, c*4 + p, 0, 0, 0, 0);
        end
        @(negedge clk); idle(); cm_slot = {IW'(31), IW'(30)}; #1;
        checks++; if (cnt0 !== 6'd32) begin errors++; $display("FAIL fill_cnt: got %0d want 32", cnt0); end
        checks++; if (cnt1 !== 6'd32) begin errors++; $display("FAIL fill_cnt_byp: got %0d want 32", cnt1); end
        checks++; if (o0_done !== 2'b11) begin errors++; $display("FAIL fill_read: got %b want 11", o0_done); end
        flush = 1'b1; set_wb(0, 3, 1, 0, 0, 0);
        @(negedge clk); idle(); #1;
        checks++; if (cnt0 !== 6'd0) begin errors++; $display("FAIL flush_cnt: got %0d want 0", cnt0); end
        for (int s = 0; s < 32; s++) begin
            cm_slot = {IW'(s), IW'(s)}; #1;
            checks++; if ({rd(0, 0), rd(0, 1)} !== '0) begin errors++; $display("FAIL flush_read slot %0d: got %h %h want 0", s, rd(0, 0), rd(0, 1)); end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk); idle(); set_wb(1, 9, 0, 0, 1, 5); cm_slot[IW +: IW] = 9; #1;
        checks++; if (rd(1, 1) !== mk(1, 0, 0, 1, 5)) begin errors++; $display("FAIL bypass_rec: got %h want %h", rd(1, 1), mk(1, 0, 0, 1, 5)); end
        checks++; if (o0_done[1] !== 1'b0) begin errors++; $display("FAIL nobypass_rec: got %b want 0", o0_done[1]); end
        @(negedge clk); idle(); flush = 1'b1; set_wb(1, 11, 0, 0, 0, 0);
        cm_slot = {IW'(11), IW'(9)}; #1;
        checks++; if (rd(1, 1) !== mk(0, 0, 0, 0, 0)) begin errors++; $display("FAIL bypass_flush: got %h want 0", rd(1, 1)); end
        checks++; if (rd(1, 0) !== mk(1, 0, 0, 1, 5)) begin errors++; $display("FAIL stored_during_flush: got %h want %h", rd(1, 0), mk(1, 0, 0, 1, 5)); end
        @(negedge clk); idle(); #1;
        checks++; if (cnt1 !== 6'd0) begin errors++; $display("FAIL bypass_flush_cnt: got %0d want 0", cnt1); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); idle();
        for (int p = 0; p < 4; p++) set_wb(p, p, p == 0, 0, 0, 0);
        @(negedge clk); idle(); #1;
        checks++; if (cnt0 !== 6'd4) begin errors++; $display("FAIL prefill_cnt: got %0d want 4", cnt0); end
        cm_slot = {IW'(1), IW'(0)}; set_wb(1, 1, 0, 0, 1, 2); #1;
        rst = 1'b1; #1;
        checks++; if ({cnt0, cnt1} !== '0) begin errors++; $display("FAIL arst_cnt: got %0d %0d want 0", cnt0, cnt1); end
        checks++; if ({rd(0, 0), rd(0, 1)} !== '0) begin errors++; $display("FAIL arst_rec: got %h %h want 0", rd(0, 0), rd(0, 1)); end
        checks++; if ({rd(1, 0), rd(1, 1)} !== '0) begin errors++; $display("FAIL arst_bypass: got %h %h want 0", rd(1, 0), rd(1, 1)); end
        @(negedge clk); rst = 1'b0; idle();
        @(negedge clk); #1;
        checks++; if (cnt0 !== 6'd0 || o0_done !== 2'b00) begin errors++; $display("FAIL post_arst: got cnt %0d done %b want 0", cnt0, o0_done); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_wb_latency();
        test_merge();
        test_clear_priority();
        test_fill_flush();
        test_bypass();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
